decode_queue: RTL and testbench
===============================

DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter INST_W, default 32, instruction width in bits.
REQ-002 Parameter PC_W, default 32, next-PC width in bits.
REQ-003 Parameter DEPTH, default 2, number of decoded-entry slots; power of two, minimum 2.
REQ-004 Parameter DEC_W, default from the shared package, decoded-word width.
REQ-005 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port in_valid, input, 1, fetch presents an instruction.
REQ-008 Port in_ready, output, 1, queue accepts the instruction this cycle.
REQ-009 Port in_inst, input, INST_W, raw instruction.
REQ-010 Port in_npc, input, PC_W, next PC of the instruction.
REQ-011 Port flush, input, 1, discard all held and incoming entries.
REQ-012 Port out_valid, output, 1, head entry is available.
REQ-013 Port out_ready, input, 1, issue consumes the head entry.
REQ-014 Port out_word, output, DEC_W, decoded word of the head entry.
REQ-015 Port count, output, clog2(DEPTH)+1, number of occupied entries.

Function
REQ-016 The input handshake SHALL fire when in_valid and in_ready are both 1; the output handshake SHALL fire when out_valid and out_ready are both 1.
REQ-017 in_ready SHALL equal (count < DEPTH) and SHALL have no combinational path from out_ready.
REQ-018 The input SHALL be decoded combinationally at accept time, and the packed decoded word SHALL be written to the tail slot: rs1/rs2/rd addresses, use flags, immediate, opcode class, mem read/write, npc.
REQ-019 An accepted entry SHALL become visible on out_valid/out_word exactly one cycle after acceptance; there SHALL be no same-cycle bypass.
REQ-020 out_valid SHALL equal (count != 0), and out_word SHALL be the oldest entry, in strict FIFO order.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH.
REQ-022 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-023 When full, push SHALL be blocked even if a pop occurs in the same cycle.
REQ-024 When empty, out_ready SHALL be ignored; count SHALL never underflow.
REQ-025 flush SHALL take priority over push and pop: the next cycle shows count=0 and both pointers at 0, and any same-cycle input handshake is discarded.
REQ-026 While out_valid=1 and out_ready=0, out_word SHALL be held stable.

Reset
REQ-027 rst_n low SHALL asynchronously clear count, both pointers, and out_valid to 0; in_ready SHALL then read 1.
REQ-028 Slot storage SHALL NOT be reset; out_word is don't-care while out_valid=0.
REQ-029 Reset asserted mid-stream SHALL drop every entry; no partial entry SHALL appear after release.

Configuration
REQ-030 With DECODE_ILLEGAL_TRAP_EN defined, an opcode absent from the package legal-opcode table SHALL set the illegal bit in the decoded word, force all use flags and mem read/write to 0, and still occupy a slot.
REQ-031 Without DECODE_ILLEGAL_TRAP_EN, the illegal bit SHALL be tied to 0 and unknown opcodes SHALL decode with the package default fields.

Structure
REQ-032 The shared package SHALL hold DEC_W, the decoded-word field offsets, the opcode and instruction-class constants, and the legal-opcode table.
REQ-033 One combinational sub-module, decode_core (instruction in, decoded word out), SHALL be instantiated once at the write port.

Verification
REQ-034 Reset, then push in_inst=32'h20220005 (ADDI r2,r1,5) with npc=32'h104 -> next cycle out_valid=1, rs1=1, rd=2, imm=5, use_imm=1, npc=32'h104, count=1.
REQ-035 DEPTH=2, out_ready=0, push 3 back-to-back -> in_ready=0 after the 2nd push, count=2, the 3rd instruction is not accepted until a pop.
REQ-036 Full queue, in_valid=1, out_ready=1 for one cycle -> pop occurs, push blocked, count=1; the next cycle the push is accepted.
REQ-037 count=2 with flush=1 and in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, and the flushed input never appears.
REQ-038 Push 5 instructions through DEPTH=4 with random out_ready -> output order equals input order across pointer wrap.
REQ-039 With DECODE_ILLEGAL_TRAP_EN, push opcode 6'h3F -> entry has illegal=1 and mem read/write=0; without the macro -> illegal=0.

Source files
------------

// File: rtl/decode_queue_pkg.sv
// Shared decode definitions: decoded-word layout, opcode/class constants and the legal-opcode table.
// The table is consulted by decode_core only when DECODE_ILLEGAL_TRAP_EN is defined.
package decode_queue_pkg;

    localparam int NPC_W = 32;
    localparam int REG_W = 5;
    localparam int IMM_W = 32;
    localparam int CLS_W = 3;

    // Bit offsets of each field inside the packed decoded word (LSB first)
    localparam int OFF_RS1     = 0;
    localparam int OFF_RS2     = 5;
    localparam int OFF_RD      = 10;
    localparam int OFF_USE_RS1 = 15;
    localparam int OFF_USE_RS2 = 16;
    localparam int OFF_USE_RD  = 17;
    localparam int OFF_USE_IMM = 18;
    localparam int OFF_IMM     = 19;
    localparam int OFF_CLS     = 51;
    localparam int OFF_MEM_RD  = 54;
    localparam int OFF_MEM_WR  = 55;
    localparam int OFF_ILLEGAL = 56;
    localparam int OFF_NPC     = 57;
    localparam int DEC_W       = 89;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    typedef enum logic [CLS_W-1:0] {
        CLS_NONE   = 3'd0,
        CLS_ALU    = 3'd1,
        CLS_ALUI   = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5,
        CLS_JUMP   = 3'd6
    } inst_class_e;

    // Field order mirrors the OFF_* offsets, most significant field first
    typedef struct packed {
        logic [NPC_W-1:0] npc;
        logic             illegal;
        logic             mem_wr;
        logic             mem_rd;
        inst_class_e      cls;
        logic [IMM_W-1:0] imm;
        logic             use_imm;
        logic             use_rd;
        logic             use_rs2;
        logic             use_rs1;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rs1;
    } dec_word_t;

    localparam int NUM_LEGAL = 8;
    localparam logic [5:0] LEGAL_OPS [NUM_LEGAL] = '{
        6'h00, 6'h02, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B
    };

    function automatic logic is_legal_op(input logic [5:0] op);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_LEGAL; i++) begin
            if (LEGAL_OPS[i] == op) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/decode_queue_core.sv
// Combinational instruction decoder feeding the queue write port.
// DECODE_ILLEGAL_TRAP_EN: unknown opcodes raise the illegal bit and have all use/mem flags cleared.
module decode_core
    import decode_queue_pkg::*;
(
    input  logic [31:0]      inst,
    input  logic [NPC_W-1:0] npc,
    output dec_word_t        word
);

    logic [5:0] op;

    assign op = inst[31:26];

    // Start from the raw register fields and a sign-extended immediate; each class enables what it uses
    always_comb begin
        word         = '0;
        word.rs1     = inst[25:21];
        word.rs2     = inst[20:16];
        word.rd      = inst[15:11];
        word.imm     = {{16{inst[15]}}, inst[15:0]};
        word.cls     = CLS_NONE;
        word.npc     = npc;
        case (op)
            OP_RTYPE: begin
                word.use_rs1 = 1'b1;
                word.use_rs2 = 1'b1;
                word.use_rd  = 1'b1;
                word.imm     = '0;
                word.cls     = CLS_ALU;
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                word.rd      = inst[20:16];
                word.use_rs1 = 1'b1;
                word.use_rd  = 1'b1;
                word.use_imm = 1'b1;
                word.cls     = CLS_ALUI;
            end
            OP_LW: begin
                word.rd      = inst[20:16];
                word.use_rs1 = 1'b1;
                word.use_rd  = 1'b1;
                word.use_imm = 1'b1;
                word.mem_rd  = 1'b1;
                word.cls     = CLS_LOAD;
            end
            OP_SW: begin
                word.use_rs1 = 1'b1;
                word.use_rs2 = 1'b1;
                word.use_imm = 1'b1;
                word.mem_wr  = 1'b1;
                word.cls     = CLS_STORE;
            end
            OP_BEQ: begin
                word.use_rs1 = 1'b1;
                word.use_rs2 = 1'b1;
                word.use_imm = 1'b1;
                word.cls     = CLS_BRANCH;
            end
            OP_J: begin
                word.imm     = {6'b0, inst[25:0]};
                word.use_imm = 1'b1;
                word.cls     = CLS_JUMP;
            end
            default: ;
        endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (!is_legal_op(op)) begin
            word.illegal = 1'b1;
            word.use_rs1 = 1'b0;
            word.use_rs2 = 1'b0;
            word.use_rd  = 1'b0;
            word.use_imm = 1'b0;
            word.mem_rd  = 1'b0;
            word.mem_wr  = 1'b0;
        end
`else
        word.illegal = 1'b0;
`endif
    end

endmodule

// File: rtl/decode_queue.sv
// Decode queue: decodes fetched instructions at accept time and holds them in a small FIFO for issue.
// Illegal-opcode trapping in decode_core is enabled by defining DECODE_ILLEGAL_TRAP_EN.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int INST_W = 32,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 2,
    parameter int DEC_W  = decode_queue_pkg::DEC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INST_W-1:0]        in_inst,
    input  logic [PC_W-1:0]          in_npc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DEC_W-1:0]         out_word,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    dec_word_t        dec_word;
    logic [DEC_W-1:0] slots [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    decode_core u_decode_core (
        .inst (32'(in_inst)),
        .npc  (NPC_W'(in_npc)),
        .word (dec_word)
    );

    // in_ready depends only on registered count, so there is no path from out_ready
    assign in_ready  = (count < FULL_COUNT);
    assign out_valid = (count != '0);
    assign out_word  = slots[rd_ptr];
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: ;
            endcase
        end
    end

    // Slot storage is deliberately left out of reset; occupancy alone says what is valid
    always_ff @(posedge clk) begin
        if (push) slots[wr_ptr] <= DEC_W'(dec_word);
    end

endmodule

// File: tb/tb_decode_queue.sv
// Randomized bench for decode_queue: two instances (DEPTH 2 and 4) checked against queue-based reference models.
// Expected illegal-bit behaviour follows DECODE_ILLEGAL_TRAP_EN.
module tb_decode_queue;
    import decode_queue_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [31:0]      in_inst;
    logic [31:0]      in_npc;
    logic             flush;
    logic             out_ready;

    logic             in_ready2, out_valid2;
    logic [DEC_W-1:0] out_word2;
    logic [1:0]       count2;
    logic             in_ready4, out_valid4;
    logic [DEC_W-1:0] out_word4;
    logic [2:0]       count4;

    logic [DEC_W-1:0] q2 [$];
    logic [DEC_W-1:0] q4 [$];

    int checkCount = 0;
    int failCount  = 0;

    decode_queue #(.INST_W(32), .PC_W(32), .DEPTH(2)) u_dq2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_inst(in_inst), .in_npc(in_npc), .flush(flush), .out_valid(out_valid2),
        .out_ready(out_ready), .out_word(out_word2), .count(count2)
    );

    decode_queue #(.INST_W(32), .PC_W(32), .DEPTH(4)) u_dq4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_inst(in_inst), .in_npc(in_npc), .flush(flush), .out_valid(out_valid4),
        .out_ready(out_ready), .out_word(out_word4), .count(count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference decode written from the instruction-set rules, assembled by field offset
    function automatic logic [DEC_W-1:0] refDecode(input logic [31:0] inst, input logic [31:0] npc);
        logic [DEC_W-1:0] w;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2, ud, ui, mr, mw, ill;
        logic [31:0] imm;
        logic [2:0]  cls;
        rs1 = inst[25:21];
        rs2 = inst[20:16];
        rd  = inst[15:11];
        imm = {{16{inst[15]}}, inst[15:0]};
        {u1, u2, ud, ui, mr, mw, ill} = '0;
        cls = 3'd0;
        case (inst[31:26])
            6'h00: begin u1 = 1; u2 = 1; ud = 1; imm = '0; cls = 3'd1; end
            6'h08, 6'h0C, 6'h0D: begin rd = inst[20:16]; u1 = 1; ud = 1; ui = 1; cls = 3'd2; end
            6'h23: begin rd = inst[20:16]; u1 = 1; ud = 1; ui = 1; mr = 1; cls = 3'd3; end
            6'h2B: begin u1 = 1; u2 = 1; ui = 1; mw = 1; cls = 3'd4; end
            6'h04: begin u1 = 1; u2 = 1; ui = 1; cls = 3'd5; end
            6'h02: begin imm = {6'b0, inst[25:0]}; ui = 1; cls = 3'd6; end
            default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                ill = 1'b1;
`endif
            end
        endcase
        w = '0;
        w[OFF_RS1 +: 5]  = rs1;
        w[OFF_RS2 +: 5]  = rs2;
        w[OFF_RD +: 5]   = rd;
        w[OFF_USE_RS1]   = u1;
        w[OFF_USE_RS2]   = u2;
        w[OFF_USE_RD]    = ud;
        w[OFF_USE_IMM]   = ui;
        w[OFF_IMM +: 32] = imm;
        w[OFF_CLS +: 3]  = cls;
        w[OFF_MEM_RD]    = mr;
        w[OFF_MEM_WR]    = mw;
        w[OFF_ILLEGAL]   = ill;
        w[OFF_NPC +: 32] = npc;
        return w;
    endfunction

    function automatic logic [31:0] randInst();
        logic [5:0] ops [10];
        ops = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h3F, 6'h11};
        return {ops[$urandom_range(0, 9)], 26'($urandom)};
    endfunction

    // One clock: compare both instances against their models at negedge, then advance the models
    task automatic applyStimulus();
        logic push2, pop2, push4, pop4;
        logic [DEC_W-1:0] w;
        @(negedge clk);
        checkOutput("in_ready2", in_ready2, q2.size() < 2);
        checkOutput("out_valid2", out_valid2, q2.size() != 0);
        checkOutput("count2", count2, q2.size());
        if (q2.size() != 0) checkOutput("out_word2", out_word2, q2[0]);
        checkOutput("in_ready4", in_ready4, q4.size() < 4);
        checkOutput("out_valid4", out_valid4, q4.size() != 0);
        checkOutput("count4", count4, q4.size());
        if (q4.size() != 0) checkOutput("out_word4", out_word4, q4[0]);
        w     = refDecode(in_inst, in_npc);
        push2 = in_valid && (q2.size() < 2);
        pop2  = out_ready && (q2.size() != 0);
        push4 = in_valid && (q4.size() < 4);
        pop4  = out_ready && (q4.size() != 0);
        @(posedge clk);
        if (flush) begin
            q2.delete();
            q4.delete();
        end else begin
            if (pop2)  void'(q2.pop_front());
            if (push2) q2.push_back(w);
            if (pop4)  void'(q4.pop_front());
            if (push4) q4.push_back(w);
        end
        #1;
    endtask

    initial begin
        logic expIll;
        rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_npc = '0; flush = 1'b0; out_ready = 1'b0;
        #3;
        checkOutput("rst_count2", count2, 0);
        checkOutput("rst_out_valid2", out_valid2, 0);
        checkOutput("rst_in_ready2", in_ready2, 1);
        checkOutput("rst_count4", count4, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADDI r2,r1,5 becomes visible one cycle after acceptance
        in_valid = 1'b1; in_inst = 32'h20220005; in_npc = 32'h104;
        applyStimulus();
        in_valid = 1'b0;
        checkOutput("addi_valid", out_valid2, 1);
        checkOutput("addi_rs1", out_word2[OFF_RS1 +: 5], 1);
        checkOutput("addi_rd", out_word2[OFF_RD +: 5], 2);
        checkOutput("addi_imm", out_word2[OFF_IMM +: 32], 5);
        checkOutput("addi_use_imm", out_word2[OFF_USE_IMM], 1);
        checkOutput("addi_npc", out_word2[OFF_NPC +: 32], 32'h104);
        checkOutput("addi_count", count2, 1);
        out_ready = 1'b1;
        applyStimulus();
        out_ready = 1'b0;

        // Fill the DEPTH=2 queue and keep presenting a third instruction
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_inst = randInst(); in_npc = $urandom;
            applyStimulus();
            if (i == 1) begin
                checkOutput("full_in_ready", in_ready2, 0);
                checkOutput("full_count", count2, 2);
            end
        end
        checkOutput("third_blocked", count2, 2);
        out_ready = 1'b1;
        applyStimulus();
        checkOutput("pop_push_blocked", count2, 1);
        out_ready = 1'b0;
        applyStimulus();
        checkOutput("push_after_pop", count2, 2);

        // Flush wins over a same-cycle push
        flush = 1'b1; in_inst = randInst(); in_npc = $urandom;
        applyStimulus();
        flush = 1'b0; in_valid = 1'b0;
        checkOutput("flush_count2", count2, 0);
        checkOutput("flush_valid2", out_valid2, 0);
        checkOutput("flush_count4", count4, 0);

        // Unknown opcode still occupies a slot
        in_valid = 1'b1; in_inst = {6'h3F, 26'h0A5A5A5}; in_npc = 32'h200;
        applyStimulus();
        in_valid = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        expIll = 1'b1;
`else
        expIll = 1'b0;
`endif
        checkOutput("ill_valid", out_valid2, 1);
        checkOutput("ill_bit", out_word2[OFF_ILLEGAL], expIll);
        checkOutput("ill_mem", {out_word2[OFF_MEM_WR], out_word2[OFF_MEM_RD]}, 0);
        out_ready = 1'b1;
        applyStimulus();

        // Random traffic exercises pointer wrap in both depths
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inst   = randInst();
            in_npc    = $urandom;
            out_ready = $urandom_range(0, 1) == 1;
            flush     = ($urandom_range(0, 31) == 0);
            applyStimulus();
        end
        flush = 1'b0;

        // Reset in the middle of a stream drops everything
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_inst = randInst(); in_npc = $urandom;
            applyStimulus();
        end
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("mid_rst_count2", count2, 0);
        checkOutput("mid_rst_valid2", out_valid2, 0);
        checkOutput("mid_rst_ready2", in_ready2, 1);
        checkOutput("mid_rst_count4", count4, 0);
        q2.delete();
        q4.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 40; i++) begin
            in_valid  = $urandom_range(0, 1) == 1;
            in_inst   = randInst();
            in_npc    = $urandom;
            out_ready = $urandom_range(0, 1) == 1;
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
